// File: rtl/stack_ctrl.sv
// Data-stack controller: sequences stack opcodes into memory read/write traffic and owns the stack pointer.
// Define STACK_GUARD_EN to enable overflow/underflow checking and the sticky o_ERR flags.
module stack_ctrl #(
  parameter logic [15:0] BASE  = 16'hF000,
  parameter int          DEPTH = 256
) (
  input  logic        c_CLOCK,
  input  logic        c_RESET,
  input  logic        i_VALID,
  output logic        o_READY,
  input  logic [2:0]  i_OPCODE,
  input  logic [15:0] i_VALUE,
  input  logic [15:0] i_OP1,
  input  logic [15:0] i_OP2,
  output logic [15:0] o_RADDR,
  output logic [15:0] o_WADDR,
  output logic [15:0] o_WDATA,
  output logic        o_WRITE,
  output logic [15:0] o_DEPTH,
  input  logic        i_CLRERR,
  output logic [1:0]  o_ERR
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_OVER = 3'd5;
  localparam logic [2:0] OP_REPL = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;
  localparam logic [15:0] DEPTH_MAX = 16'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_EXEC2, S_SETTLE} state_t;

  state_t      state_p0, state_n;
  logic [2:0]  op_p0;
  logic [15:0] op1_p0;
  logic [15:0] depth_p0, depth_n;
  logic [15:0] waddr_p0, waddr_n;
  logic [15:0] wdata_p0, wdata_n;
  logic        wr_p0, wr_n;
  logic        accept, is_nop, load;
  logic [1:0]  new_err;

  assign o_READY = (state_p0 == S_IDLE);
  assign accept  = i_VALID && o_READY;
  assign is_nop  = (i_OPCODE == OP_NOP) || (i_OPCODE == OP_RSV);
  assign load    = accept && !is_nop && (new_err == 2'b00);

`ifdef STACK_GUARD_EN
  logic       udf_c, ovf_c;
  logic [1:0] err_p0;

  assign udf_c = (((i_OPCODE == OP_POP) || (i_OPCODE == OP_DUP) || (i_OPCODE == OP_REPL))
                  && (depth_p0 == 16'd0))
              || (((i_OPCODE == OP_SWAP) || (i_OPCODE == OP_OVER)) && (depth_p0 < 16'd2));
  assign ovf_c = ((i_OPCODE == OP_PUSH) || (i_OPCODE == OP_DUP) || (i_OPCODE == OP_OVER))
              && (depth_p0 == DEPTH_MAX);
  // Underflow has priority so OVER on a short stack reports underflow only
  assign new_err = !accept ? 2'b00 : udf_c ? 2'b10 : ovf_c ? 2'b01 : 2'b00;

  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET) err_p0 <= 2'b00;
    else         err_p0 <= (i_CLRERR ? 2'b00 : err_p0) | new_err;
  end
  assign o_ERR = err_p0;
`else
  logic unused_clrerr;
  assign unused_clrerr = i_CLRERR;
  assign new_err       = 2'b00;
  assign o_ERR         = 2'b00;
`endif

  always_comb begin
    state_n = state_p0;
    wr_n    = 1'b0;
    waddr_n = waddr_p0;
    wdata_n = wdata_p0;
    depth_n = depth_p0;
    case (state_p0)
      S_IDLE: begin
        if (load) begin
          state_n = S_EXEC;
          case (i_OPCODE)
            OP_PUSH: begin wr_n = 1'b1; waddr_n = BASE + depth_p0; wdata_n = i_VALUE; end
            OP_DUP:  begin wr_n = 1'b1; waddr_n = BASE + depth_p0; wdata_n = i_OP1;   end
            OP_OVER: begin wr_n = 1'b1; waddr_n = BASE + depth_p0; wdata_n = i_OP2;   end
            OP_REPL: begin wr_n = 1'b1; waddr_n = BASE + depth_p0 - 16'd1; wdata_n = i_VALUE; end
            OP_SWAP: begin wr_n = 1'b1; waddr_n = BASE + depth_p0 - 16'd1; wdata_n = i_OP2;   end
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        state_n = S_SETTLE;
        case (op_p0)
          OP_PUSH, OP_DUP, OP_OVER: depth_n = depth_p0 + 16'd1;
          OP_POP:                   depth_n = depth_p0 - 16'd1;
          OP_SWAP: begin
            state_n = S_EXEC2;
            wr_n    = 1'b1;
            waddr_n = BASE + depth_p0 - 16'd2;
            wdata_n = op1_p0;
          end
          default: ;
        endcase
      end
      S_EXEC2:  state_n = S_SETTLE;
      S_SETTLE: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Accept stage -> write/commit stage
  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET) begin
      state_p0 <= S_IDLE;
      op_p0    <= OP_NOP;
      depth_p0 <= 16'd0;
      waddr_p0 <= 16'd0;
      wdata_p0 <= 16'd0;
      wr_p0    <= 1'b0;
    end else begin
      state_p0 <= state_n;
      if (load) op_p0 <= i_OPCODE;
      depth_p0 <= depth_n;
      waddr_p0 <= waddr_n;
      wdata_p0 <= wdata_n;
      wr_p0    <= wr_n;
    end
  end

  always_ff @(posedge c_CLOCK) begin
    if (load) op1_p0 <= i_OP1;
  end

  assign o_WRITE = wr_p0;
  assign o_WADDR = waddr_p0;
  assign o_WDATA = wdata_p0;
  assign o_DEPTH = depth_p0;
  assign o_RADDR = BASE + depth_p0 - 16'd1;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (DEPTH=4) with a registered-output stack memory model.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  opcode = 3'd0;
  logic [15:0] value = 16'd0;
  logic [15:0] op1 = 16'd0;
  logic [15:0] op2 = 16'd0;
  logic [15:0] raddr, waddr, wdata, depth;
  logic        write;
  logic        clrerr = 1'b0;
  logic [1:0]  err;
  logic [15:0] mem [0:65535];
  int          n_cmp = 0;
  int          n_err = 0;

  stack_ctrl #(.BASE(16'hF000), .DEPTH(4)) dut (
    .c_CLOCK(clk), .c_RESET(rst), .i_VALID(valid), .o_READY(ready),
    .i_OPCODE(opcode), .i_VALUE(value), .i_OP1(op1), .i_OP2(op2),
    .o_RADDR(raddr), .o_WADDR(waddr), .o_WDATA(wdata), .o_WRITE(write),
    .o_DEPTH(depth), .i_CLRERR(clrerr), .o_ERR(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) mem[waddr] <= wdata;
    op1 <= mem[raddr];
    op2 <= mem[raddr - 16'd1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 8 && !ready; i++) tick();
    chk("ready_timeout", 16'(ready), 16'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] val);
    valid = 1'b1; opcode = op; value = val;
    tick();
    valid = 1'b0; opcode = 3'd0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] val);
    issue(op, val);
    wait_ready();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_depth", depth, 16'd0);
    chk("rst_raddr", raddr, 16'hEFFF);
    chk("rst_write", 16'(write), 16'd0);
    chk("rst_waddr", waddr, 16'd0);
    chk("rst_wdata", wdata, 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    tick();
    rst = 1'b0;

    // PUSH 1234: EXEC, SETTLE, then ready
    issue(3'd1, 16'h1234);
    chk("push_write", 16'(write), 16'd1);
    chk("push_waddr", waddr, 16'hF000);
    chk("push_wdata", wdata, 16'h1234);
    chk("push_ready_exec", 16'(ready), 16'd0);
    tick();
    chk("push_write_off", 16'(write), 16'd0);
    chk("push_depth", depth, 16'd1);
    chk("push_raddr", raddr, 16'hF000);
    chk("push_ready_settle", 16'(ready), 16'd0);
    tick();
    chk("push_ready_back", 16'(ready), 16'd1);

    // NOP and reserved are consumed in one cycle
    issue(3'd7, 16'hFFFF);
    chk("rsv_ready", 16'(ready), 16'd1);
    chk("rsv_write", 16'(write), 16'd0);
    chk("rsv_depth", depth, 16'd1);

    // SWAP of 0001 / 0002
    do_reset();
    do_op(3'd1, 16'h0001);
    do_op(3'd1, 16'h0002);
    issue(3'd4, 16'h0000);
    chk("swap_w1", 16'(write), 16'd1);
    chk("swap_a1", waddr, 16'hF001);
    chk("swap_d1", wdata, 16'h0001);
    tick();
    chk("swap_w2", 16'(write), 16'd1);
    chk("swap_a2", waddr, 16'hF000);
    chk("swap_d2", wdata, 16'h0002);
    chk("swap_ready_exec2", 16'(ready), 16'd0);
    tick();
    chk("swap_w_off", 16'(write), 16'd0);
    chk("swap_ready_settle", 16'(ready), 16'd0);
    chk("swap_depth", depth, 16'd2);
    tick();
    chk("swap_ready_back", 16'(ready), 16'd1);
    chk("swap_top", op1, 16'h0001);
    chk("swap_second", op2, 16'h0002);

    // DUP, REPLACE, OVER
    do_op(3'd3, 16'h0000);
    chk("dup_depth", depth, 16'd3);
    chk("dup_top", op1, 16'h0001);
    do_op(3'd6, 16'h00AA);
    chk("repl_depth", depth, 16'd3);
    chk("repl_top", op1, 16'h00AA);
    issue(3'd5, 16'h0000);
    chk("over_waddr", waddr, 16'hF003);
    chk("over_wdata", wdata, 16'h0001);
    wait_ready();
    chk("over_depth", depth, 16'd4);
    chk("over_top", op1, 16'h0001);
    chk("over_second", op2, 16'h00AA);

`ifdef STACK_GUARD_EN
    // Overflow at DEPTH
    issue(3'd1, 16'h5555);
    chk("ovf_write", 16'(write), 16'd0);
    chk("ovf_ready", 16'(ready), 16'd1);
    chk("ovf_err", 16'(err), 16'd1);
    chk("ovf_depth", depth, 16'd4);
    clrerr = 1'b1;
    tick();
    clrerr = 1'b0;
    chk("clr_err", 16'(err), 16'd0);
    do_op(3'd1, 16'h5555);
    chk("ovf2_err", 16'(err), 16'd1);

    // Drain, then underflow with simultaneous clear
    for (int i = 0; i < 4; i++) do_op(3'd2, 16'h0000);
    chk("drain_depth", depth, 16'd0);
    chk("drain_err", 16'(err), 16'd1);
    valid = 1'b1; opcode = 3'd2; clrerr = 1'b1;
    tick();
    valid = 1'b0; opcode = 3'd0; clrerr = 1'b0;
    chk("udf_err", 16'(err), 16'd2);
    chk("udf_depth", depth, 16'd0);
    chk("udf_write", 16'(write), 16'd0);
    clrerr = 1'b1;
    tick();
    clrerr = 1'b0;
    chk("udf_clr", 16'(err), 16'd0);

    // OVER with a single element
    do_op(3'd1, 16'h0007);
    issue(3'd5, 16'h0000);
    chk("over1_err", 16'(err), 16'd2);
    chk("over1_raddr", raddr, 16'hF000);
    chk("over1_depth", depth, 16'd1);
    chk("over1_write", 16'(write), 16'd0);
    chk("over1_ready", 16'(ready), 16'd1);
`else
    // No guard: PUSH past DEPTH still executes
    issue(3'd1, 16'h5555);
    chk("nog_write", 16'(write), 16'd1);
    chk("nog_waddr", waddr, 16'hF004);
    chk("nog_err", 16'(err), 16'd0);
    wait_ready();
    chk("nog_depth", depth, 16'd5);

    // POP on empty wraps
    do_reset();
    do_op(3'd2, 16'h0000);
    chk("wrap_depth", depth, 16'hFFFF);
    chk("wrap_raddr", raddr, 16'hEFFE);
    chk("wrap_err", 16'(err), 16'd0);
    clrerr = 1'b1;
    tick();
    clrerr = 1'b0;
    chk("wrap_clr_err", 16'(err), 16'd0);
`endif

    // Reset during the EXEC cycle of a DUP
    do_reset();
    do_op(3'd1, 16'h0009);
    issue(3'd3, 16'h0000);
    chk("dup_exec_write", 16'(write), 16'd1);
    chk("dup_exec_waddr", waddr, 16'hF001);
    chk("dup_exec_wdata", wdata, 16'h0009);
    #2 rst = 1'b1;
    #1;
    chk("abort_write", 16'(write), 16'd0);
    chk("abort_depth", depth, 16'd0);
    chk("abort_raddr", raddr, 16'hEFFF);
    chk("abort_ready", 16'(ready), 16'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_idle_depth", depth, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
